// File: rtl/video_timing_gen.sv
// Raster timing generator: cascaded loadable H/V counters that reload their
// start values on terminal count, with registered blank/sync flags and a
// one-cycle frame-start strobe. Flags are updated from the counter's next
// value, so each flag always describes the H/V value currently on the ports.
module video_timing_gen #(
    parameter int unsigned    HW         = 9,
    parameter int unsigned    VW         = 9,
    parameter logic [HW-1:0]  H_START    = 9'h080,
    parameter logic [VW-1:0]  V_START    = 9'h0F8,
    parameter logic [HW-1:0]  HBLANK_ON  = 9'h180,
    parameter logic [HW-1:0]  HBLANK_OFF = 9'h080,
    parameter logic [HW-1:0]  HSYNC_ON   = 9'h1A0,
    parameter logic [HW-1:0]  HSYNC_OFF  = 9'h1C0,
    parameter logic [VW-1:0]  VBLANK_ON  = 9'h1F0,
    parameter logic [VW-1:0]  VBLANK_OFF = 9'h110,
    parameter logic [VW-1:0]  VSYNC_ON   = 9'h1F8,
    parameter logic [VW-1:0]  VSYNC_OFF  = 9'h1FC
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          CE,
    output logic [HW-1:0] H,
    output logic [VW-1:0] V,
    output logic          H_TC,
    output logic          V_TC,
    output logic          HBLANK,
    output logic          VBLANK,
    output logic          HSYNC_n,
    output logic          VSYNC_n,
    output logic          FRAME_START
);

    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          line_wrap;
    logic          frame_wrap;
    logic          hblank_next;
    logic          hsync_n_next;
    logic          vblank_next;
    logic          vsync_n_next;

    // Terminal counts are ungated by CE, like a 161 ripple-carry output
    assign H_TC = &H;
    assign V_TC = H_TC & (&V);

    // Next counter values and flag updates for the coming edge
    always_comb begin
        line_wrap    = CE & H_TC;
        frame_wrap   = CE & V_TC;
        h_next       = H;
        v_next       = V;
        hblank_next  = HBLANK;
        hsync_n_next = HSYNC_n;
        vblank_next  = VBLANK;
        vsync_n_next = VSYNC_n;

        if (CE) begin
            h_next = H_TC ? H_START : H + HW'(1);
            // Clear is tested first so an ON==OFF pair never asserts
            if (h_next == HBLANK_OFF) begin
                hblank_next = 1'b0;
            end else if (h_next == HBLANK_ON) begin
                hblank_next = 1'b1;
            end
            if (h_next == HSYNC_OFF) begin
                hsync_n_next = 1'b1;
            end else if (h_next == HSYNC_ON) begin
                hsync_n_next = 1'b0;
            end
        end

        if (line_wrap) begin
            v_next = (&V) ? V_START : V + VW'(1);
            if (v_next == VBLANK_OFF) begin
                vblank_next = 1'b0;
            end else if (v_next == VBLANK_ON) begin
                vblank_next = 1'b1;
            end
            if (v_next == VSYNC_OFF) begin
                vsync_n_next = 1'b1;
            end else if (v_next == VSYNC_ON) begin
                vsync_n_next = 1'b0;
            end
        end
    end

    // State register; reset dominates CE and restarts the raster cleanly
    always_ff @(posedge Clk) begin
        if (Reset) begin
            H           <= H_START;
            V           <= V_START;
            HBLANK      <= 1'b1;
            VBLANK      <= 1'b1;
            HSYNC_n     <= 1'b1;
            VSYNC_n     <= 1'b1;
            FRAME_START <= 1'b0;
        end else begin
            H           <= h_next;
            V           <= v_next;
            HBLANK      <= hblank_next;
            VBLANK      <= vblank_next;
            HSYNC_n     <= hsync_n_next;
            VSYNC_n     <= vsync_n_next;
            FRAME_START <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen. Several instances share Clk/Reset/CE:
// one at default timing, and shortened rasters so frame-level behaviour is
// reachable in a few thousand cycles.
module tb_video_timing_gen;

    logic Clk;
    logic Reset;
    logic CE;

    int checks;
    int fails;

    logic [8:0] a_h, a_v;
    logic       a_htc, a_vtc, a_hblank, a_vblank, a_hsync_n, a_vsync_n, a_fs;
    logic [8:0] b_h, b_v;
    logic       b_htc, b_vtc, b_hblank, b_vblank, b_hsync_n, b_vsync_n, b_fs;
    logic [8:0] c_h, c_v;
    logic       c_htc, c_vtc, c_hblank, c_vblank, c_hsync_n, c_vsync_n, c_fs;
    logic [8:0] d_h, d_v;
    logic       d_htc, d_vtc, d_hblank, d_vblank, d_hsync_n, d_vsync_n, d_fs;

    video_timing_gen u_dut (
        .Clk(Clk), .Reset(Reset), .CE(CE), .H(a_h), .V(a_v), .H_TC(a_htc), .V_TC(a_vtc),
        .HBLANK(a_hblank), .VBLANK(a_vblank), .HSYNC_n(a_hsync_n), .VSYNC_n(a_vsync_n),
        .FRAME_START(a_fs)
    );

    // 16 pixels per line, full 264-line frame
    video_timing_gen #(.H_START(9'h1F0)) u_frame (
        .Clk(Clk), .Reset(Reset), .CE(CE), .H(b_h), .V(b_v), .H_TC(b_htc), .V_TC(b_vtc),
        .HBLANK(b_hblank), .VBLANK(b_vblank), .HSYNC_n(b_hsync_n), .VSYNC_n(b_vsync_n),
        .FRAME_START(b_fs)
    );

    // 96 pixels per line, 16 lines per frame, default sync positions
    video_timing_gen #(.H_START(9'h1A0), .V_START(9'h1F0)) u_short (
        .Clk(Clk), .Reset(Reset), .CE(CE), .H(c_h), .V(c_v), .H_TC(c_htc), .V_TC(c_vtc),
        .HBLANK(c_hblank), .VBLANK(c_vblank), .HSYNC_n(c_hsync_n), .VSYNC_n(c_vsync_n),
        .FRAME_START(c_fs)
    );

    // Same short raster with HSYNC ON == OFF
    video_timing_gen #(.H_START(9'h1A0), .V_START(9'h1F0), .HSYNC_ON(9'h1A0), .HSYNC_OFF(9'h1A0)) u_nosync (
        .Clk(Clk), .Reset(Reset), .CE(CE), .H(d_h), .V(d_v), .H_TC(d_htc), .V_TC(d_vtc),
        .HBLANK(d_hblank), .VBLANK(d_vblank), .HSYNC_n(d_hsync_n), .VSYNC_n(d_vsync_n),
        .FRAME_START(d_fs)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        CE    = 1'b1;
        step();
        step();
        checks++; if (a_h !== 9'h080) begin fails++; $display("FAIL reset_h: got %h expected 080", a_h); end
        checks++; if (a_v !== 9'h0F8) begin fails++; $display("FAIL reset_v: got %h expected 0f8", a_v); end
        checks++; if (a_hblank !== 1'b1) begin fails++; $display("FAIL reset_hblank: got %b expected 1", a_hblank); end
        checks++; if (a_vblank !== 1'b1) begin fails++; $display("FAIL reset_vblank: got %b expected 1", a_vblank); end
        checks++; if (a_hsync_n !== 1'b1) begin fails++; $display("FAIL reset_hsync_n: got %b expected 1", a_hsync_n); end
        checks++; if (a_vsync_n !== 1'b1) begin fails++; $display("FAIL reset_vsync_n: got %b expected 1", a_vsync_n); end
        checks++; if (a_fs !== 1'b0) begin fails++; $display("FAIL reset_frame_start: got %b expected 0", a_fs); end
        checks++; if (a_htc !== 1'b0) begin fails++; $display("FAIL reset_h_tc: got %b expected 0", a_htc); end
        Reset = 1'b0;
        repeat (128) step();
        checks++; if (a_h !== 9'h100) begin fails++; $display("FAIL run128_h: got %h expected 100", a_h); end
        checks++; if (a_v !== 9'h0F8) begin fails++; $display("FAIL run128_v: got %h expected 0f8", a_v); end
        checks++; if (a_hblank !== 1'b1) begin fails++; $display("FAIL run128_hblank: got %b expected 1", a_hblank); end
        repeat (256) step();
        checks++; if (a_h !== 9'h080) begin fails++; $display("FAIL run384_h: got %h expected 080", a_h); end
        checks++; if (a_v !== 9'h0F9) begin fails++; $display("FAIL run384_v: got %h expected 0f9", a_v); end
        checks++; if (a_hblank !== 1'b0) begin fails++; $display("FAIL run384_hblank: got %b expected 0", a_hblank); end
        checks++; if (a_vblank !== 1'b1) begin fails++; $display("FAIL run384_vblank: got %b expected 1", a_vblank); end
    endtask

    // Continues from H=080, V=0F9 with CE held high
    task automatic test_full_line();
        logic [8:0] h_exp;
        int low_cnt;
        h_exp   = 9'h080;
        low_cnt = 0;
        for (int i = 0; i < 384; i++) begin
            checks++; if (a_h !== h_exp) begin fails++; $display("FAIL line_h: got %h expected %h", a_h, h_exp); end
            checks++; if (a_hblank !== (h_exp >= 9'h180)) begin fails++; $display("FAIL line_hblank at H=%h: got %b expected %b", h_exp, a_hblank, (h_exp >= 9'h180)); end
            checks++; if (a_hsync_n !== !(h_exp >= 9'h1A0 && h_exp <= 9'h1BF)) begin fails++; $display("FAIL line_hsync_n at H=%h: got %b expected %b", h_exp, a_hsync_n, !(h_exp >= 9'h1A0 && h_exp <= 9'h1BF)); end
            checks++; if (a_htc !== (h_exp == 9'h1FF)) begin fails++; $display("FAIL line_h_tc at H=%h: got %b expected %b", h_exp, a_htc, (h_exp == 9'h1FF)); end
            checks++; if (a_vtc !== 1'b0) begin fails++; $display("FAIL line_v_tc at H=%h: got %b expected 0", h_exp, a_vtc); end
            if (a_hsync_n === 1'b0) low_cnt++;
            step();
            h_exp = (h_exp == 9'h1FF) ? 9'h080 : h_exp + 9'd1;
        end
        checks++; if (low_cnt != 32) begin fails++; $display("FAIL line_hsync_width: got %0d expected 32", low_cnt); end
        checks++; if (a_v !== 9'h0FA) begin fails++; $display("FAIL line_v_after: got %h expected 0fa", a_v); end
    endtask

    task automatic test_ce_toggle();
        logic [8:0] h_exp, v_exp;
        Reset = 1'b1;
        CE    = 1'b1;
        step();
        Reset = 1'b0;
        h_exp = 9'h080;
        v_exp = 9'h0F8;
        for (int k = 0; k < 768; k++) begin
            CE = (k % 2 == 0);
            step();
            if (CE) begin
                if (h_exp == 9'h1FF) begin
                    h_exp = 9'h080;
                    v_exp = v_exp + 9'd1;
                end else begin
                    h_exp = h_exp + 9'd1;
                end
            end
            checks++; if (a_h !== h_exp) begin fails++; $display("FAIL toggle_h at clk %0d: got %h expected %h", k, a_h, h_exp); end
            checks++; if (a_v !== v_exp) begin fails++; $display("FAIL toggle_v at clk %0d: got %h expected %h", k, a_v, v_exp); end
            checks++; if (a_fs !== 1'b0) begin fails++; $display("FAIL toggle_frame_start at clk %0d: got %b expected 0", k, a_fs); end
        end
        checks++; if (a_h !== 9'h080 || a_v !== 9'h0F9) begin fails++; $display("FAIL toggle_line_768: got H=%h V=%h expected H=080 V=0f9", a_h, a_v); end
        checks++; if (a_hblank !== 1'b0) begin fails++; $display("FAIL toggle_hblank: got %b expected 0", a_hblank); end
        CE = 1'b1;
    endtask

    task automatic test_full_frame();
        logic [8:0] h_exp, v_exp;
        logic fs_exp;
        int vb_lines, vs_lines, fs_cnt;
        Reset = 1'b1;
        CE    = 1'b1;
        step();
        Reset    = 1'b0;
        h_exp    = 9'h1F0;
        v_exp    = 9'h0F8;
        fs_exp   = 1'b0;
        vb_lines = 0;
        vs_lines = 0;
        fs_cnt   = 0;
        for (int i = 0; i < 4230; i++) begin
            checks++; if (b_h !== h_exp || b_v !== v_exp) begin fails++; $display("FAIL frame_hv: got %h/%h expected %h/%h", b_h, b_v, h_exp, v_exp); end
            checks++; if (b_vblank !== !(v_exp >= 9'h110 && v_exp <= 9'h1EF)) begin fails++; $display("FAIL frame_vblank at V=%h: got %b", v_exp, b_vblank); end
            checks++; if (b_vsync_n !== !(v_exp >= 9'h1F8 && v_exp <= 9'h1FB)) begin fails++; $display("FAIL frame_vsync_n at V=%h: got %b", v_exp, b_vsync_n); end
            checks++; if (b_fs !== fs_exp) begin fails++; $display("FAIL frame_start at V=%h H=%h: got %b expected %b", v_exp, h_exp, b_fs, fs_exp); end
            checks++; if (b_vtc !== (h_exp == 9'h1FF && v_exp == 9'h1FF)) begin fails++; $display("FAIL frame_v_tc at V=%h H=%h: got %b", v_exp, h_exp, b_vtc); end
            if (h_exp == 9'h1F0 && b_vblank === 1'b0) vb_lines++;
            if (h_exp == 9'h1F0 && b_vsync_n === 1'b0) vs_lines++;
            if (b_fs === 1'b1) fs_cnt++;
            step();
            fs_exp = (h_exp == 9'h1FF && v_exp == 9'h1FF);
            if (h_exp == 9'h1FF) begin
                h_exp = 9'h1F0;
                v_exp = (v_exp == 9'h1FF) ? 9'h0F8 : v_exp + 9'd1;
            end else begin
                h_exp = h_exp + 9'd1;
            end
        end
        checks++; if (vb_lines != 224) begin fails++; $display("FAIL frame_active_lines: got %0d expected 224", vb_lines); end
        checks++; if (vs_lines != 4) begin fails++; $display("FAIL frame_vsync_lines: got %0d expected 4", vs_lines); end
        checks++; if (fs_cnt != 1) begin fails++; $display("FAIL frame_start_count: got %0d expected 1", fs_cnt); end
    endtask

    task automatic test_frame_ce_toggle();
        logic [8:0] h_exp, v_exp;
        logic fs_exp;
        int fs_cnt;
        Reset = 1'b1;
        CE    = 1'b1;
        step();
        Reset  = 1'b0;
        h_exp  = 9'h1F0;
        v_exp  = 9'h0F8;
        fs_cnt = 0;
        for (int k = 0; k < 8460; k++) begin
            CE = (k % 2 == 0);
            step();
            fs_exp = CE && h_exp == 9'h1FF && v_exp == 9'h1FF;
            if (CE) begin
                if (h_exp == 9'h1FF) begin
                    h_exp = 9'h1F0;
                    v_exp = (v_exp == 9'h1FF) ? 9'h0F8 : v_exp + 9'd1;
                end else begin
                    h_exp = h_exp + 9'd1;
                end
            end
            checks++; if (b_h !== h_exp || b_v !== v_exp) begin fails++; $display("FAIL ftoggle_hv at clk %0d: got %h/%h expected %h/%h", k, b_h, b_v, h_exp, v_exp); end
            checks++; if (b_fs !== fs_exp) begin fails++; $display("FAIL ftoggle_frame_start at clk %0d: got %b expected %b", k, b_fs, fs_exp); end
            if (b_fs === 1'b1) fs_cnt++;
        end
        checks++; if (fs_cnt != 1) begin fails++; $display("FAIL ftoggle_pulse_cycles: got %0d expected 1", fs_cnt); end
        CE = 1'b1;
    endtask

    task automatic test_reset_mid_sync();
        int n;
        Reset = 1'b1;
        CE    = 1'b1;
        step();
        Reset = 1'b0;
        n = 0;
        while (!(c_h === 9'h1A5 && c_v === 9'h1F9) && n < 2000) begin
            step();
            n++;
        end
        checks++; if (n != 869) begin fails++; $display("FAIL midsync_reach: got %0d edges expected 869", n); end
        checks++; if (c_hsync_n !== 1'b0 || c_vsync_n !== 1'b0) begin fails++; $display("FAIL midsync_in_sync: got hs=%b vs=%b expected 0/0", c_hsync_n, c_vsync_n); end
        Reset = 1'b1;
        step();
        checks++; if (c_h !== 9'h1A0 || c_v !== 9'h1F0) begin fails++; $display("FAIL midsync_reset_hv: got %h/%h expected 1a0/1f0", c_h, c_v); end
        checks++; if (c_hsync_n !== 1'b1 || c_vsync_n !== 1'b1) begin fails++; $display("FAIL midsync_reset_syncs: got hs=%b vs=%b expected 1/1", c_hsync_n, c_vsync_n); end
        checks++; if (c_hblank !== 1'b1 || c_vblank !== 1'b1) begin fails++; $display("FAIL midsync_reset_blanks: got hb=%b vb=%b expected 1/1", c_hblank, c_vblank); end
        checks++; if (c_fs !== 1'b0) begin fails++; $display("FAIL midsync_reset_fs: got %b expected 0", c_fs); end
        Reset = 1'b0;
        step();
        checks++; if (c_h !== 9'h1A1 || c_hsync_n !== 1'b1) begin fails++; $display("FAIL midsync_release: got H=%h hs=%b expected 1a1/1", c_h, c_hsync_n); end
    endtask

    task automatic test_equal_on_off();
        int fs_cnt;
        Reset = 1'b1;
        CE    = 1'b1;
        step();
        Reset  = 1'b0;
        fs_cnt = 0;
        for (int i = 0; i < 1540; i++) begin
            checks++; if (d_hsync_n !== 1'b1) begin fails++; $display("FAIL nosync_hsync_n at H=%h V=%h: got %b expected 1", d_h, d_v, d_hsync_n); end
            if (d_fs === 1'b1) fs_cnt++;
            step();
        end
        checks++; if (fs_cnt != 1) begin fails++; $display("FAIL nosync_frame_done: got %0d expected 1", fs_cnt); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        Reset  = 1'b1;
        CE     = 1'b0;
        test_reset();
        test_full_line();
        test_ce_toggle();
        test_full_frame();
        test_frame_ce_toggle();
        test_reset_mid_sync();
        test_equal_on_off();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
